ace_ar_arbiter: RTL and testbench

Round-robin arbiter that shares the interconnect's single downstream ACE AR/R port between NUM_MASTERS cache controllers. It prefixes each granted transaction's ID with the master index and routes R beats back to the originating master by that prefix. Optionally, it caps outstanding reads per master. It sits between the cache_controller instances and the interconnect read path.

---
 rtl/ace_ar_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_ace_ar_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ace_ar_arbiter.sv
// Round-robin AR arbiter sharing one downstream ACE read port; R beats routed back by ID prefix.
// Optional per-master outstanding-read cap: define AR_ARB_OUTSTANDING_LIMIT_EN.
module ace_ar_arbiter #(
    parameter int NUM_MASTERS     = 4,
    parameter int ID_WIDTH        = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 4,
    localparam int IDX_W          = $clog2(NUM_MASTERS),
    localparam int P              = ID_WIDTH + ADDR_WIDTH + 21
) (
    input  logic                            aclk,
    input  logic                            arst,
    input  logic [NUM_MASTERS-1:0]          s_ar_valid,
    output logic [NUM_MASTERS-1:0]          s_ar_ready,
    input  logic [NUM_MASTERS*P-1:0]        s_ar_payload,
    output logic                            m_ar_valid,
    input  logic                            m_ar_ready,
    output logic [P+IDX_W-1:0]              m_ar_payload,
    input  logic                            m_r_valid,
    output logic                            m_r_ready,
    input  logic [IDX_W+ID_WIDTH-1:0]       m_r_id,
    input  logic [DATA_WIDTH-1:0]           m_r_data,
    input  logic [3:0]                      m_r_resp,
    input  logic                            m_r_last,
    output logic [NUM_MASTERS-1:0]          s_r_valid,
    input  logic [NUM_MASTERS-1:0]          s_r_ready,
    output logic [ID_WIDTH-1:0]             s_r_id,
    output logic [DATA_WIDTH-1:0]           s_r_data,
    output logic [3:0]                      s_r_resp,
    output logic                            s_r_last,
    output logic                            route_err
);

    localparam int unsigned NM = NUM_MASTERS;

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15)
    begin : g_param_range
        $error("ace_ar_arbiter: parameter out of range");
    end

    typedef enum logic {IDLE, BUSY} state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic                   m_ar_valid_q, m_ar_valid_d;
    logic [P+IDX_W-1:0]     m_ar_payload_q, m_ar_payload_d;
    logic                   route_err_q, route_err_d;

    logic [NUM_MASTERS-1:0] eligible;
    logic                   any_eligible;
    logic                   found_hi;
    logic [IDX_W-1:0]       win_hi, win_lo, winner;
    logic [P-1:0]           sel_payload;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_idx_ok;
    logic                   r_sel_ready;

`ifdef AR_ARB_OUTSTANDING_LIMIT_EN
    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

    logic [3:0] outst_q [NUM_MASTERS];
    logic [3:0] outst_d [NUM_MASTERS];

    always_comb begin : elig_mask
        eligible = '0;
        for (int unsigned i = 0; i < NM; i++) begin
            eligible[i] = s_ar_valid[i] && (outst_q[i] != MAX_CNT);
        end
    end

    // Grant and RLAST in the same cycle cancel; never wrap below zero.
    always_comb begin : outst_next
        for (int unsigned i = 0; i < NM; i++) begin
            outst_d[i] = outst_q[i];
            if (s_ar_ready[i] && !(s_r_valid[i] && m_r_ready && m_r_last)) begin
                outst_d[i] = outst_q[i] + 4'd1;
            end else if (!s_ar_ready[i] && s_r_valid[i] && m_r_ready && m_r_last
                         && outst_q[i] != 4'd0) begin
                outst_d[i] = outst_q[i] - 4'd1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        for (int unsigned i = 0; i < NM; i++) begin
            if (arst) outst_q[i] <= '0;
            else      outst_q[i] <= outst_d[i];
        end
    end
`else
    always_comb begin : elig_mask
        eligible = s_ar_valid;
    end
`endif

    // First eligible index at or above rr_ptr, else the lowest eligible (wrap).
    always_comb begin : arbitrate
        any_eligible = 1'b0;
        found_hi     = 1'b0;
        win_hi       = '0;
        win_lo       = '0;
        for (int unsigned i = 0; i < NM; i++) begin
            if (eligible[i]) begin
                if (!any_eligible) win_lo = IDX_W'(i);
                if (!found_hi && i >= 32'(rr_ptr_q)) begin
                    win_hi   = IDX_W'(i);
                    found_hi = 1'b1;
                end
                any_eligible = 1'b1;
            end
        end
        winner      = found_hi ? win_hi : win_lo;
        sel_payload = '0;
        s_ar_ready  = '0;
        for (int unsigned i = 0; i < NM; i++) begin
            if (winner == IDX_W'(i)) begin
                sel_payload   = s_ar_payload[i*P +: P];
                s_ar_ready[i] = (state_q == IDLE) && any_eligible && !arst;
            end
        end
    end

    always_comb begin : r_route
        r_idx       = m_r_id[IDX_W+ID_WIDTH-1:ID_WIDTH];
        r_idx_ok    = (32'(r_idx) < NM);
        r_sel_ready = 1'b0;
        s_r_valid   = '0;
        for (int unsigned i = 0; i < NM; i++) begin
            if (r_idx == IDX_W'(i)) begin
                s_r_valid[i] = m_r_valid && !arst;
                r_sel_ready  = s_r_ready[i];
            end
        end
        // Unroutable beats are sunk so the downstream port cannot deadlock.
        m_r_ready = !arst && (r_idx_ok ? r_sel_ready : 1'b1);
        s_r_id    = arst ? '0 : m_r_id[ID_WIDTH-1:0];
        s_r_data  = arst ? '0 : m_r_data;
        s_r_resp  = arst ? '0 : m_r_resp;
        s_r_last  = arst ? 1'b0 : m_r_last;
    end

    always_comb begin : fsm
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        m_ar_valid_d   = m_ar_valid_q;
        m_ar_payload_d = m_ar_payload_q;
        route_err_d    = route_err_q | (m_r_valid & ~r_idx_ok);
        case (state_q)
            IDLE: begin
                if (any_eligible) begin
                    m_ar_payload_d = {winner, sel_payload};
                    m_ar_valid_d   = 1'b1;
                    rr_ptr_d       = (winner == IDX_W'(NM - 1)) ? '0 : winner + IDX_W'(1);
                    state_d        = BUSY;
                end
            end
            BUSY: begin
                if (m_ar_ready) begin
                    m_ar_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            state_q        <= IDLE;
            rr_ptr_q       <= '0;
            m_ar_valid_q   <= 1'b0;
            m_ar_payload_q <= '0;
            route_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            m_ar_valid_q   <= m_ar_valid_d;
            m_ar_payload_q <= m_ar_payload_d;
            route_err_q    <= route_err_d;
        end
    end

    assign m_ar_valid   = m_ar_valid_q;
    assign m_ar_payload = m_ar_payload_q;
    assign route_err    = route_err_q;

endmodule

// File: tb/tb_ace_ar_arbiter.sv
// Directed self-checking bench: a 4-master instance and a 3-master instance (index wrap, bad routes).
module tb_ace_ar_arbiter;

    localparam int P = 57;

    logic aclk = 1'b0;
    logic arst;
    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0]     a_ar_valid, a_ar_ready;
    logic [4*P-1:0] a_ar_payload;
    logic           a_m_ar_valid, a_m_ar_ready;
    logic [P+1:0]   a_m_ar_payload;
    logic           a_m_r_valid, a_m_r_ready, a_m_r_last;
    logic [5:0]     a_m_r_id;
    logic [63:0]    a_m_r_data, a_s_r_data;
    logic [3:0]     a_m_r_resp, a_s_r_resp;
    logic [3:0]     a_s_r_valid, a_s_r_ready, a_s_r_id;
    logic           a_s_r_last, a_route_err;

    logic [2:0]     b_ar_valid, b_ar_ready;
    logic [3*P-1:0] b_ar_payload;
    logic           b_m_ar_valid, b_m_ar_ready;
    logic [P+1:0]   b_m_ar_payload;
    logic           b_m_r_valid, b_m_r_ready, b_m_r_last;
    logic [5:0]     b_m_r_id;
    logic [63:0]    b_m_r_data, b_s_r_data;
    logic [3:0]     b_m_r_resp, b_s_r_resp;
    logic [2:0]     b_s_r_valid, b_s_r_ready;
    logic [3:0]     b_s_r_id;
    logic           b_s_r_last, b_route_err;

    ace_ar_arbiter #(.NUM_MASTERS(4), .MAX_OUTSTANDING(2)) u_dut4 (
        .aclk(aclk), .arst(arst),
        .s_ar_valid(a_ar_valid), .s_ar_ready(a_ar_ready), .s_ar_payload(a_ar_payload),
        .m_ar_valid(a_m_ar_valid), .m_ar_ready(a_m_ar_ready), .m_ar_payload(a_m_ar_payload),
        .m_r_valid(a_m_r_valid), .m_r_ready(a_m_r_ready), .m_r_id(a_m_r_id),
        .m_r_data(a_m_r_data), .m_r_resp(a_m_r_resp), .m_r_last(a_m_r_last),
        .s_r_valid(a_s_r_valid), .s_r_ready(a_s_r_ready), .s_r_id(a_s_r_id),
        .s_r_data(a_s_r_data), .s_r_resp(a_s_r_resp), .s_r_last(a_s_r_last),
        .route_err(a_route_err)
    );

    ace_ar_arbiter #(.NUM_MASTERS(3)) u_dut3 (
        .aclk(aclk), .arst(arst),
        .s_ar_valid(b_ar_valid), .s_ar_ready(b_ar_ready), .s_ar_payload(b_ar_payload),
        .m_ar_valid(b_m_ar_valid), .m_ar_ready(b_m_ar_ready), .m_ar_payload(b_m_ar_payload),
        .m_r_valid(b_m_r_valid), .m_r_ready(b_m_r_ready), .m_r_id(b_m_r_id),
        .m_r_data(b_m_r_data), .m_r_resp(b_m_r_resp), .m_r_last(b_m_r_last),
        .s_r_valid(b_s_r_valid), .s_r_ready(b_s_r_ready), .s_r_id(b_s_r_id),
        .s_r_data(b_s_r_data), .s_r_resp(b_s_r_resp), .s_r_last(b_s_r_last),
        .route_err(b_route_err)
    );

    // id, addr, len, size, burst, domain, snoop, bar
    function automatic logic [P-1:0] mk(input logic [3:0] id, input logic [31:0] addr);
        return {id, addr, 8'h07, 3'd3, 2'd1, 2'd2, 4'hA, 2'd1};
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_inputs();
        a_ar_valid = '0; a_ar_payload = '0; a_m_ar_ready = 1'b0;
        a_m_r_valid = 1'b0; a_m_r_id = '0; a_m_r_data = '0; a_m_r_resp = '0;
        a_m_r_last = 1'b0; a_s_r_ready = '0;
        b_ar_valid = '0; b_ar_payload = '0; b_m_ar_ready = 1'b0;
        b_m_r_valid = 1'b0; b_m_r_id = '0; b_m_r_data = '0; b_m_r_resp = '0;
        b_m_r_last = 1'b0; b_s_r_ready = '0;
    endtask

    task automatic do_reset();
        arst = 1'b1;
        clear_inputs();
        tick();
        tick();
        arst = 1'b0;
    endtask

    task automatic test_reset();
        arst = 1'b1;
        clear_inputs();
        tick();
        a_ar_valid = '1; a_m_r_valid = 1'b1; a_m_r_id = 6'h15; a_s_r_ready = '1;
        a_m_r_data = 64'h1234; a_m_r_last = 1'b1;
        tick();
        n_checks++; if (a_ar_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_s_ar_ready: got %b exp 0000", a_ar_ready); end
        n_checks++; if (a_m_r_ready !== 1'b0) begin n_fail++; $display("FAIL reset_m_r_ready: got %b exp 0", a_m_r_ready); end
        n_checks++; if (a_s_r_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_s_r_valid: got %b exp 0000", a_s_r_valid); end
        n_checks++; if (a_s_r_data !== 64'h0) begin n_fail++; $display("FAIL reset_s_r_data: got %h exp 0", a_s_r_data); end
        n_checks++; if (a_m_ar_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_ar_valid: got %b exp 0", a_m_ar_valid); end
        n_checks++; if (a_m_ar_payload !== '0) begin n_fail++; $display("FAIL reset_m_ar_payload: got %h exp 0", a_m_ar_payload); end
        n_checks++; if (a_route_err !== 1'b0) begin n_fail++; $display("FAIL reset_route_err4: got %b exp 0", a_route_err); end
        n_checks++; if (b_route_err !== 1'b0) begin n_fail++; $display("FAIL reset_route_err3: got %b exp 0", b_route_err); end
        n_checks++; if (b_m_ar_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_ar_valid3: got %b exp 0", b_m_ar_valid); end
        clear_inputs();
        arst = 1'b0;
    endtask

    task automatic test_single_and_backpressure();
        logic [P+1:0] exp_pl;
        do_reset();
        exp_pl = {2'd2, mk(4'd3, 32'h1000)};
        a_ar_payload[2*P +: P] = mk(4'd3, 32'h1000);
        a_ar_valid = 4'b0100;
        #1;
        n_checks++; if (a_ar_ready !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b exp 0100", a_ar_ready); end
        n_checks++; if (a_m_ar_valid !== 1'b0) begin n_fail++; $display("FAIL single_pre_valid: got %b exp 0", a_m_ar_valid); end
        tick();
        a_ar_valid = 4'b0000;
        #1;
        n_checks++; if (a_m_ar_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b exp 1", a_m_ar_valid); end
        n_checks++; if (a_m_ar_payload !== exp_pl) begin n_fail++; $display("FAIL single_payload: got %h exp %h", a_m_ar_payload, exp_pl); end
        a_ar_valid = 4'b1111;
        a_ar_payload = {4{mk(4'hF, 32'hFFFF_0000)}};
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++; if (a_m_ar_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b exp 1", c, a_m_ar_valid); end
            n_checks++; if (a_m_ar_payload !== exp_pl) begin n_fail++; $display("FAIL bp_payload[%0d]: got %h exp %h", c, a_m_ar_payload, exp_pl); end
            n_checks++; if (a_ar_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_s_ar_ready[%0d]: got %b exp 0000", c, a_ar_ready); end
        end
        a_m_ar_ready = 1'b1;
        tick();
        a_m_ar_ready = 1'b0;
        #1;
        n_checks++; if (a_m_ar_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %b exp 0", a_m_ar_valid); end
        // rr_ptr now 3, so with all valid the next grant goes to master 3
        n_checks++; if (a_ar_ready !== 4'b1000) begin n_fail++; $display("FAIL rr_after_2: got %b exp 1000", a_ar_ready); end
        a_ar_valid = '0;
        tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++) a_ar_payload[i*P +: P] = mk(4'(i + 1), 32'(32'h100 * (i + 1)));
        a_ar_valid = 4'b1111;
        a_m_ar_ready = 1'b1;
        #1;
        for (int g = 0; g < 5; g++) begin
            logic [1:0] e;
            logic [P+1:0] exp_pl;
            e = 2'(g % 4);
            exp_pl = {e, mk(4'(e) + 4'd1, 32'h100 * (32'(e) + 1))};
            n_checks++; if (a_ar_ready !== 4'(1 << e)) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b exp %b", g, a_ar_ready, 4'(1 << e)); end
            tick();
            n_checks++; if (a_m_ar_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid[%0d]: got %b exp 1", g, a_m_ar_valid); end
            n_checks++; if (a_m_ar_payload !== exp_pl) begin n_fail++; $display("FAIL rr_payload[%0d]: got %h exp %h", g, a_m_ar_payload, exp_pl); end
            n_checks++; if (a_ar_ready !== 4'b0000) begin n_fail++; $display("FAIL rr_busy_ready[%0d]: got %b exp 0000", g, a_ar_ready); end
            tick();
        end
        a_ar_valid = '0;
        a_m_ar_ready = 1'b0;
        tick();
    endtask

    task automatic test_r_routing();
        a_m_r_valid = 1'b1; a_m_r_id = 6'h25; a_m_r_data = 64'hDEAD_BEEF_0123_4567;
        a_m_r_resp = 4'b1001; a_m_r_last = 1'b1; a_s_r_ready = 4'b0000;
        #1;
        n_checks++; if (a_s_r_valid !== 4'b0100) begin n_fail++; $display("FAIL r_valid: got %b exp 0100", a_s_r_valid); end
        n_checks++; if (a_s_r_id !== 4'h5) begin n_fail++; $display("FAIL r_id: got %h exp 5", a_s_r_id); end
        n_checks++; if (a_s_r_data !== 64'hDEAD_BEEF_0123_4567) begin n_fail++; $display("FAIL r_data: got %h exp deadbeef01234567", a_s_r_data); end
        n_checks++; if (a_s_r_resp !== 4'b1001) begin n_fail++; $display("FAIL r_resp: got %b exp 1001", a_s_r_resp); end
        n_checks++; if (a_s_r_last !== 1'b1) begin n_fail++; $display("FAIL r_last: got %b exp 1", a_s_r_last); end
        n_checks++; if (a_m_r_ready !== 1'b0) begin n_fail++; $display("FAIL r_ready_blocked: got %b exp 0", a_m_r_ready); end
        a_s_r_ready = 4'b1011;
        #1;
        n_checks++; if (a_m_r_ready !== 1'b0) begin n_fail++; $display("FAIL r_ready_others: got %b exp 0", a_m_r_ready); end
        a_s_r_ready = 4'b0100;
        #1;
        n_checks++; if (a_m_r_ready !== 1'b1) begin n_fail++; $display("FAIL r_ready_pass: got %b exp 1", a_m_r_ready); end
        a_m_r_id = 6'h3A; a_m_r_last = 1'b0;
        #1;
        n_checks++; if (a_s_r_valid !== 4'b1000) begin n_fail++; $display("FAIL r_valid_m3: got %b exp 1000", a_s_r_valid); end
        n_checks++; if (a_s_r_id !== 4'hA) begin n_fail++; $display("FAIL r_id_m3: got %h exp a", a_s_r_id); end
        n_checks++; if (a_m_r_ready !== 1'b0) begin n_fail++; $display("FAIL r_ready_m3: got %b exp 0", a_m_r_ready); end
        a_m_r_valid = 1'b0;
        #1;
        n_checks++; if (a_s_r_valid !== 4'b0000) begin n_fail++; $display("FAIL r_idle_valid: got %b exp 0000", a_s_r_valid); end
        n_checks++; if (a_route_err !== 1'b0) begin n_fail++; $display("FAIL r_route_err4: got %b exp 0", a_route_err); end
        clear_inputs();
        tick();
    endtask

    task automatic test_outstanding();
        do_reset();
        a_ar_payload[0 +: P] = mk(4'd1, 32'h2000);
        a_ar_valid = 4'b0001;
        a_m_ar_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++; if (a_ar_ready !== 4'b0001) begin n_fail++; $display("FAIL ost_grant[%0d]: got %b exp 0001", k, a_ar_ready); end
            tick();
            tick();
        end
        #1;
`ifdef AR_ARB_OUTSTANDING_LIMIT_EN
        n_checks++; if (a_ar_ready !== 4'b0000) begin n_fail++; $display("FAIL ost_blocked: got %b exp 0000", a_ar_ready); end
        tick();
        n_checks++; if (a_ar_ready !== 4'b0000) begin n_fail++; $display("FAIL ost_blocked2: got %b exp 0000", a_ar_ready); end
        n_checks++; if (a_m_ar_valid !== 1'b0) begin n_fail++; $display("FAIL ost_no_issue: got %b exp 0", a_m_ar_valid); end
        a_m_r_valid = 1'b1; a_m_r_id = 6'h01; a_m_r_last = 1'b1; a_s_r_ready = 4'b0001;
        #1;
        n_checks++; if (a_m_r_ready !== 1'b1) begin n_fail++; $display("FAIL ost_rlast_ready: got %b exp 1", a_m_r_ready); end
        n_checks++; if (a_ar_ready !== 4'b0000) begin n_fail++; $display("FAIL ost_same_cycle: got %b exp 0000", a_ar_ready); end
        tick();
        a_m_r_valid = 1'b0; a_m_r_last = 1'b0;
        #1;
        n_checks++; if (a_ar_ready !== 4'b0001) begin n_fail++; $display("FAIL ost_release: got %b exp 0001", a_ar_ready); end
`else
        n_checks++; if (a_ar_ready !== 4'b0001) begin n_fail++; $display("FAIL nolimit_third: got %b exp 0001", a_ar_ready); end
`endif
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_nonpow2_and_route_err();
        do_reset();
        for (int i = 0; i < 3; i++) b_ar_payload[i*P +: P] = mk(4'(i + 4), 32'(32'hA000 + i));
        b_ar_valid = 3'b111;
        b_m_ar_ready = 1'b1;
        #1;
        for (int g = 0; g < 4; g++) begin
            logic [1:0] e;
            logic [P+1:0] exp_pl;
            e = 2'(g % 3);
            exp_pl = {e, mk(4'(e) + 4'd4, 32'hA000 + 32'(e))};
            n_checks++; if (b_ar_ready !== 3'(1 << e)) begin n_fail++; $display("FAIL wrap_grant[%0d]: got %b exp %b", g, b_ar_ready, 3'(1 << e)); end
            tick();
            n_checks++; if (b_m_ar_payload !== exp_pl) begin n_fail++; $display("FAIL wrap_payload[%0d]: got %h exp %h", g, b_m_ar_payload, exp_pl); end
            tick();
        end
        b_ar_valid = '0;
        b_m_ar_ready = 1'b0;
        b_m_r_valid = 1'b1; b_m_r_id = {2'd1, 4'd2}; b_s_r_ready = 3'b010;
        #1;
        n_checks++; if (b_s_r_valid !== 3'b010) begin n_fail++; $display("FAIL m3_route_valid: got %b exp 010", b_s_r_valid); end
        n_checks++; if (b_m_r_ready !== 1'b1) begin n_fail++; $display("FAIL m3_route_ready: got %b exp 1", b_m_r_ready); end
        b_m_r_id = {2'd3, 4'd7}; b_s_r_ready = 3'b000;
        #1;
        n_checks++; if (b_m_r_ready !== 1'b1) begin n_fail++; $display("FAIL bad_route_ready: got %b exp 1", b_m_r_ready); end
        n_checks++; if (b_s_r_valid !== 3'b000) begin n_fail++; $display("FAIL bad_route_valid: got %b exp 000", b_s_r_valid); end
        n_checks++; if (b_route_err !== 1'b0) begin n_fail++; $display("FAIL bad_route_err_pre: got %b exp 0", b_route_err); end
        tick();
        b_m_r_valid = 1'b0; b_m_r_id = '0;
        #1;
        n_checks++; if (b_route_err !== 1'b1) begin n_fail++; $display("FAIL bad_route_err_set: got %b exp 1", b_route_err); end
        tick();
        tick();
        n_checks++; if (b_route_err !== 1'b1) begin n_fail++; $display("FAIL bad_route_err_sticky: got %b exp 1", b_route_err); end
        n_checks++; if (a_route_err !== 1'b0) begin n_fail++; $display("FAIL route_err4_clean: got %b exp 0", a_route_err); end
    endtask

    initial begin
        arst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_and_backpressure();
        test_round_robin();
        test_r_routing();
        test_outstanding();
        test_nonpow2_and_route_err();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
